time_set_buttons: RTL and testbench

TIME_SET_BUTTONS -- requirements
Module: time_set_buttons

---
 rtl/time_set_buttons.sv | 151 +++++++++++++++
 tb/tb_time_set_buttons.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/time_set_buttons.sv
// Debounced left/up time-set buttons with up auto-repeat.
// Emits single-cycle edit pulses gated by i_enable.
module time_set_buttons #(
  parameter int CLOCK_FREQUENCY  = 27_000_000,
  parameter int DEBOUNCE_DIV     = 100,
  parameter int REPEAT_DELAY_DIV = 2,
  parameter int REPEAT_RATE_DIV  = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_left_n,
  input  logic i_btn_up_n,
  input  logic i_enable,
  output logic o_time_left,
  output logic o_time_up,
  output logic o_up_repeating
);

  localparam int DEB_RAW = CLOCK_FREQUENCY / DEBOUNCE_DIV;
  localparam int DLY_RAW = CLOCK_FREQUENCY / REPEAT_DELAY_DIV;
  localparam int RAT_RAW = CLOCK_FREQUENCY / REPEAT_RATE_DIV;
  localparam int DEB = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int DLY = (DLY_RAW < 1) ? 1 : DLY_RAW;
  localparam int RAT = (RAT_RAW < 1) ? 1 : RAT_RAW;
  localparam int TMAX = (DLY > RAT) ? DLY : RAT;
  localparam int DW = $clog2(DEB + 1);
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(DLY - 1);
  localparam logic [TW-1:0] RAT_LAST = TW'(RAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  // index 0 = left, index 1 = up; 1 = released
  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    stable;
  logic [1:0]    stable_q;
  logic [1:0]    armed;
  logic [1:0]    warm;
  logic [1:0]    press;
  logic [DW-1:0] cnt [2];

  state_t        state;
  logic [TW-1:0] timer;
  logic          left_pulse;
  logic          up_pulse;
  logic          repeating;

  assign raw   = {i_btn_up_n, i_btn_left_n};
  assign press = armed & stable_q & ~stable;

  // A button must be seen released after reset before it may pulse,
  // so a button held through reset stays silent until re-pressed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1       <= '1;
      s2       <= '1;
      stable   <= '1;
      stable_q <= '1;
      armed    <= '0;
      warm     <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      warm     <= {warm[0], 1'b1};
      s1       <= raw;
      s2       <= s1;
      stable_q <= stable;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != stable[i]) begin
          if (cnt[i] == DEB_LAST) begin
            stable[i] <= s2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + DW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
        if (warm[1] && s2[i] && stable[i]) armed[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      left_pulse <= 1'b0;
      up_pulse   <= 1'b0;
      repeating  <= 1'b0;
    end else if (!i_enable) begin
      state      <= IDLE;
      timer      <= '0;
      left_pulse <= 1'b0;
      up_pulse   <= 1'b0;
      repeating  <= 1'b0;
    end else begin
      left_pulse <= press[0];
      up_pulse   <= 1'b0;
      unique case (state)
        IDLE: begin
          repeating <= 1'b0;
          // up press is ignored while left is held
          if (press[1] && stable[0]) begin
            state    <= DELAY;
            timer    <= '0;
            up_pulse <= 1'b1;
          end
        end
        DELAY: begin
          if (stable[1]) begin
            state <= IDLE;
          end else if (timer == DLY_LAST) begin
            state     <= REPEAT;
            timer     <= '0;
            up_pulse  <= 1'b1;
            repeating <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REPEAT: begin
          if (stable[1]) begin
            state     <= IDLE;
            repeating <= 1'b0;
          end else if (timer == RAT_LAST) begin
            timer    <= '0;
            up_pulse <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          repeating <= 1'b0;
        end
      endcase
    end
  end

  assign o_time_left    = left_pulse & i_enable;
  assign o_time_up      = up_pulse & i_enable;
  assign o_up_repeating = repeating & i_enable;

endmodule

// File: tb/tb_time_set_buttons.sv
// Directed bench for time_set_buttons at 1 kHz:
// debounce 10, repeat delay 500, repeat rate 125.
module tb_time_set_buttons;

  logic clk;
  logic rst_n;
  logic btn_left_n;
  logic btn_up_n;
  logic enable;
  logic time_left;
  logic time_up;
  logic up_repeating;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int p;
  int up_q[$];
  int left_q[$];
  int exp_up[5] = '{13, 513, 638, 763, 888};

  time_set_buttons #(
    .CLOCK_FREQUENCY (1000),
    .DEBOUNCE_DIV    (100),
    .REPEAT_DELAY_DIV(2),
    .REPEAT_RATE_DIV (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_btn_left_n  (btn_left_n),
    .i_btn_up_n    (btn_up_n),
    .i_enable      (enable),
    .o_time_left   (time_left),
    .o_time_up     (time_up),
    .o_up_repeating(up_repeating)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (time_up === 1'b1) up_q.push_back(cyc);
    if (time_left === 1'b1) left_q.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    up_q.delete();
    left_q.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    btn_left_n = 1'b1;
    btn_up_n   = 1'b1;
    enable     = 1'b1;
    tick(3);
    chk("rst_left", int'(time_left), 0);
    chk("rst_up", int'(time_up), 0);
    chk("rst_rep", int'(up_repeating), 0);
    rst_n = 1'b1;
    tick(5);

    // clean left press
    clr();
    btn_left_n = 1'b0;
    p = cyc;
    tick(50);
    btn_left_n = 1'b1;
    tick(30);
    chk("left_count", left_q.size(), 1);
    if (left_q.size() > 0) chk("left_latency", left_q[0] - p, 13);
    chk("left_no_up", up_q.size(), 0);

    // up held 1000 cycles with auto-repeat
    clr();
    btn_up_n = 1'b0;
    p = cyc;
    tick(512);
    chk("rep_before", int'(up_repeating), 0);
    tick(1);
    chk("rep_start", int'(up_repeating), 1);
    tick(487);
    btn_up_n = 1'b1;
    tick(12);
    chk("rep_hold", int'(up_repeating), 1);
    tick(1);
    chk("rep_end", int'(up_repeating), 0);
    tick(20);
    chk("up_count", up_q.size(), 5);
    if (up_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("up_time", up_q[i] - p, exp_up[i]);

    // bouncing up
    clr();
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn_up_n = ~btn_up_n;
      tick(1);
    end
    btn_up_n = 1'b0;
    tick(30);
    btn_up_n = 1'b1;
    tick(30);
    chk("bounce_count", up_q.size(), 1);

    // left held blocks up
    clr();
    btn_left_n = 1'b0;
    tick(30);
    btn_up_n = 1'b0;
    tick(600);
    btn_left_n = 1'b1;
    btn_up_n   = 1'b1;
    tick(30);
    chk("block_left", left_q.size(), 1);
    chk("block_up", up_q.size(), 0);
    btn_up_n = 1'b0;
    tick(30);
    btn_up_n = 1'b1;
    tick(30);
    chk("block_repress", up_q.size(), 1);

    // enable low while held
    clr();
    enable   = 1'b0;
    btn_up_n = 1'b0;
    tick(600);
    chk("dis_up", up_q.size(), 0);
    enable = 1'b1;
    tick(200);
    chk("dis_en_up", up_q.size(), 0);
    chk("dis_en_rep", int'(up_repeating), 0);
    btn_up_n = 1'b1;
    tick(30);
    btn_up_n = 1'b0;
    tick(30);
    btn_up_n = 1'b1;
    tick(30);
    chk("dis_repress", up_q.size(), 1);

    // reset during repeat
    btn_up_n = 1'b0;
    tick(600);
    chk("pre_rst_rep", int'(up_repeating), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rep", int'(up_repeating), 0);
    chk("async_up", int'(time_up), 0);
    clr();
    tick(3);
    rst_n = 1'b1;
    tick(400);
    chk("post_rst_up", up_q.size(), 0);
    chk("post_rst_rep", int'(up_repeating), 0);
    btn_up_n = 1'b1;
    tick(30);
    btn_up_n = 1'b0;
    tick(30);
    btn_up_n = 1'b1;
    tick(30);
    chk("post_rst_repress", up_q.size(), 1);
    chk("post_rst_left", left_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
